// File: rtl/aes_pkg.sv
// Shared AES definitions: state/byte types, block constants and the
// FIPS-197 forward and inverse S-box lookup functions.
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [7:0]   byte_t;

    // Columns per state (AES Nb) and bytes per column.
    localparam int NB       = 4;
    localparam int COL_BYTES = 4;

    // Sequencer states of the iterative SubBytes stage.
    typedef enum logic [1:0] {
        SB_IDLE = 2'd0,
        SB_BUSY = 2'd1,
        SB_DONE = 2'd2
    } sb_fsm_t;

    // Forward S-box, entry 0x00 in the top byte, entry 0xFF in the bottom byte.
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Inverse S-box, same packing as the forward table.
    localparam logic [2047:0] INV_SBOX_FLAT = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Forward substitution of one byte.
    function automatic byte_t sbox(input byte_t b);
        return SBOX_FLAT[2047 - 8 * int'(b) -: 8];
    endfunction

    // Inverse substitution of one byte.
    function automatic byte_t inv_sbox(input byte_t b);
        return INV_SBOX_FLAT[2047 - 8 * int'(b) -: 8];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational single-byte S-box with forward/inverse select; shared by
// the SubBytes stage and the key-expansion block.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in,
    input  logic       inv,
    output logic [7:0] out
);

    // Pick the table by direction; both lookups are pure ROM.
    always_comb begin
        out = inv ? inv_sbox(in) : sbox(in);
    end

endmodule

// File: rtl/sub_bytes_seq.sv
// Iterative SubBytes / InvSubBytes: one 32-bit column per cycle through four
// shared S-boxes, four compute cycles per 128-bit state, ready/valid on both
// sides with single-cycle hand-off from DONE straight into the next state.
module sub_bytes_seq
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] subIn,
    input  logic         inv,
    input  logic         inValid,
    output logic         inReady,
    output logic [127:0] subOut,
    output logic         outValid,
    input  logic         outReady
);

    sb_fsm_t      r_fsm;
    sb_fsm_t      w_fsm_next;
    logic [1:0]   r_col;
    logic         r_inv;
    state_t       r_state;

    logic         w_accept;
    logic [31:0]  w_col_data;
    logic [31:0]  w_sub_col;
    state_t       w_state_upd;

    // Handshake outputs; inReady only looks at outReady while results sit in DONE.
    always_comb begin
        inReady  = (r_fsm == SB_IDLE) || ((r_fsm == SB_DONE) && outReady);
        outValid = (r_fsm == SB_DONE);
        w_accept = inValid && inReady;
    end

    // Next-state logic for the IDLE -> BUSY -> DONE sequencer.
    always_comb begin
        // NOTE: default first so every path assigns w_fsm_next and no latch is inferred.
        w_fsm_next = r_fsm;
        unique case (r_fsm)
            SB_IDLE: begin
                if (inValid) begin
                    w_fsm_next = SB_BUSY;
                end
            end
            SB_BUSY: begin
                if (r_col == 2'd3) begin
                    w_fsm_next = SB_DONE;
                end
            end
            SB_DONE: begin
                if (outReady && inValid) begin
                    w_fsm_next = SB_BUSY;
                end else if (outReady) begin
                    w_fsm_next = SB_IDLE;
                end
            end
            default: begin
                w_fsm_next = SB_IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register sees pre-edge values.
        if (rst) begin
            r_fsm <= SB_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // Select the column currently being substituted.
    always_comb begin
        w_col_data = r_state[127:96];
        unique case (r_col)
            2'd0: w_col_data = r_state[127:96];
            2'd1: w_col_data = r_state[95:64];
            2'd2: w_col_data = r_state[63:32];
            2'd3: w_col_data = r_state[31:0];
            default: w_col_data = r_state[127:96];
        endcase
    end

    // Four shared S-boxes, byte r of the column at bits [31-8r -: 8].
    for (genvar g = 0; g < COL_BYTES; g++) begin : g_sbox
        aes_sbox u_sbox (
            .in  (w_col_data[31 - 8 * g -: 8]),
            .inv (r_inv),
            .out (w_sub_col[31 - 8 * g -: 8])
        );
    end

    // Splice the substituted column back into its slot of the state.
    always_comb begin
        w_state_upd = r_state;
        unique case (r_col)
            2'd0: w_state_upd[127:96] = w_sub_col;
            2'd1: w_state_upd[95:64]  = w_sub_col;
            2'd2: w_state_upd[63:32]  = w_sub_col;
            2'd3: w_state_upd[31:0]   = w_sub_col;
            default: w_state_upd = r_state;
        endcase
    end

    // State register, column counter and latched direction.
    always_ff @(posedge clk) begin
        // NOTE: the 128-bit state is a plain register, so it is reset to give a defined subOut of zero.
        if (rst) begin
            r_state <= '0;
            r_col   <= 2'd0;
            r_inv   <= 1'b0;
        end else if (w_accept) begin
            r_state <= subIn;
            r_col   <= 2'd0;
            r_inv   <= inv;
        end else if (r_fsm == SB_BUSY) begin
            r_state <= w_state_upd;
            r_col   <= r_col + 2'd1;
        end
    end

    // The result is the state register itself; no path from subIn.
    always_comb begin
        subOut = r_state;
    end

endmodule
